spi_peripheral: RTL and testbench
=================================

# spi_peripheral

- SPI mode-0 write-only target that sits between the chip pins (`ui_in` SCLK/COPI/nCS) and the PWM peripheral.
- Captures 16-bit write frames and updates five 8-bit control registers: output enables, PWM enables and PWM duty cycle.
- The registers drive the downstream PWM peripheral directly.
- The block is in the `clk` domain and oversamples the SPI pins; there is no SPI-clocked logic.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer flops per SPI input, before the edge-detect flop.
- `MAX_ADDR`, 4: highest valid register address.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `sclk` in 1: SPI clock, asynchronous to `clk`.
- `copi` in 1: SPI data in, asynchronous.
- `ncs` in 1: SPI chip select, active low, asynchronous.
- `en_reg_out_7_0` out 8: address 0x00, output enables for outputs 7..0.
- `en_reg_out_15_8` out 8: address 0x01, output enables for outputs 15..8.
- `en_reg_pwm_7_0` out 8: address 0x02, PWM mode enables for outputs 7..0.
- `en_reg_pwm_15_8` out 8: address 0x03, PWM mode enables for outputs 15..8.
- `pwm_duty_cycle` out 8: address 0x04, duty cycle (0x00 = 0 %, 0xFF = always high).
- `txn_valid` out 1: one-cycle pulse when a register is written.
- `txn_error` out 1: one-cycle pulse when a write frame is discarded.

## Operation
- **Frame format:** MSB first, 16 bits.
  - bit15 = R/W (1 = write).
  - bits14:8 = address (7 bits).
  - bits7:0 = data.
- **Sampling:** COPI is sampled on the detected SCLK rising edge. The SCLK falling edge is ignored.
- **Synchronization:** each input passes through `SYNC_STAGES` flops, then one history flop. Edges are detected as sync & ~hist (rising) and ~sync & hist (falling).
- **FSM states:**
  - ARMED (reset state): waits for nCS to be high.
  - IDLE: nCS high. A detected nCS fall clears the shift register and the bit counter, then goes to SHIFT.
  - SHIFT:
    - On each SCLK rise, shift the synchronized COPI into the LSB and increment the 5-bit counter, which saturates at 17.
    - A detected nCS rise goes to COMMIT.
  - COMMIT: one cycle, evaluates the frame, then goes to IDLE.
- **Commit rules** (evaluated in COMMIT):
  - count == 16, R/W = 1, addr ≤ `MAX_ADDR`: write data to the addressed register and pulse `txn_valid`.
  - count == 16, R/W = 0: read frame. Silently ignored, no pulse.
  - count == 16, R/W = 1, addr > `MAX_ADDR`: no write, pulse `txn_error`.
  - count ≠ 16 (short frame, long frame, or zero bits): no write, pulse `txn_error`.
- **Reset behaviour:**
  - `rst` clears all five registers to 0x00, clears `txn_valid` and `txn_error` to 0, the synchronizers, the shift register and the counter, and enters ARMED.
  - A reset during a frame discards that frame.
  - ARMED ignores SCLK until nCS is observed high. A frame already in progress at reset release is therefore never captured.
- **Register write semantics:**
  - Registers change only in COMMIT and hold their value otherwise.
  - A write of the same value still pulses `txn_valid`.

## Timing
- **Input latency:** an SPI pin change is visible to the edge detector `SYNC_STAGES` + 1 clk edges after it is sampled.
- **Write latency:** the register updates, and `txn_valid`/`txn_error` assert, on the 4th `clk` rising edge after nCS rises (default `SYNC_STAGES`). The pulse lasts exactly one cycle.
- **SCLK constraints:**
  - SCLK high and low phases must each be ≥ 3 `clk` periods.
  - COPI must be stable for ≥ 3 `clk` periods around the SCLK rise.
  - Violations are out of contract; no detection is required.
- **nCS constraints:**
  - nCS high time between frames must be ≥ 4 `clk` periods. The FSM returns to IDLE before the next fall is detected.
  - nCS fall to first SCLK rise must be ≥ 3 `clk` periods.
- **Simultaneous events:**
  - If an SCLK rise and an nCS rise are detected in the same cycle, the nCS rise wins. That SCLK edge is not shifted.
  - An SCLK rise while in IDLE or ARMED has no effect.
- **Output timing:** all outputs are registered, with no combinational path from the SPI pins.

## Test plan
- Reset, then frame 0x80F0 (write, addr 0x00, data 0xF0) → `en_reg_out_7_0` = 0xF0, one `txn_valid` pulse, all other registers 0x00.
- Frames 0x8480 then 0x82FF → `pwm_duty_cycle` = 0x80 and `en_reg_pwm_7_0` = 0xFF. Each updates exactly 4 clk edges after its nCS rise.
- Frame 0x00AA (read) → no register change, no pulse. Frame 0xB0AA (addr 0x30) → no change, one `txn_error` pulse.
- 15-bit frame and 17-bit frame, each carrying 0x81xx → `en_reg_out_15_8` unchanged, `txn_error` pulsed once per frame.
- Assert `rst` after 8 bits of 0x80FF, release it while nCS is still low, finish the frame → all registers 0x00, no pulse. The next full frame 0x80FF is accepted.
- Back-to-back writes to addresses 0..4 with minimum nCS high time (4 clk) → all five registers hold their written values and `txn_valid` pulses 5 times.

Source files
------------

// File: rtl/spi_peripheral.sv
// spi_peripheral: oversampled SPI mode-0 write-only target driving five 8-bit PWM control registers
module spi_peripheral #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       txn_valid,
  output logic       txn_error
);
  typedef enum logic [1:0] {ARMED, IDLE, SHIFT, COMMIT} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
  logic sclk_hist_q, ncs_hist_q;
  logic [15:0] sh_q, sh_d;
  logic [4:0] cnt_q, cnt_d;
  logic [7:0] regs_q [5];
  logic [7:0] regs_d [5];
  logic valid_q, valid_d, error_q, error_d;
  logic sclk_s, copi_s, ncs_s, sclk_rise, ncs_rise, ncs_fall, full, wr_ok;
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist_q;
  assign ncs_rise = ncs_s & ~ncs_hist_q;
  assign ncs_fall = ~ncs_s & ncs_hist_q;
  assign full = cnt_q == 5'd16;
  assign wr_ok = full && sh_q[15] && sh_q[14:8] <= 7'(MAX_ADDR);
  always_comb begin
    state_d = state_q;
    sh_d = sh_q;
    cnt_d = cnt_q;
    regs_d = regs_q;
    valid_d = 1'b0;
    error_d = 1'b0;
    unique case (state_q)
      ARMED: state_d = ncs_s ? IDLE : ARMED;
      IDLE: if (ncs_fall) begin
        state_d = SHIFT;
        sh_d = '0;
        cnt_d = '0;
      end
      SHIFT: if (ncs_rise) state_d = COMMIT;
      else if (sclk_rise) begin
        sh_d = {sh_q[14:0], copi_s};
        cnt_d = (cnt_q == 5'd17) ? cnt_q : cnt_q + 5'd1;
      end
      COMMIT: begin
        state_d = IDLE;
        for (int i = 0; i < 5; i++) if (wr_ok && sh_q[14:8] == 7'(i)) regs_d[i] = sh_q[7:0];
        valid_d = wr_ok;
        error_d = full ? (sh_q[15] && !wr_ok) : 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARMED;
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q <= '0;
      sclk_hist_q <= 1'b0;
      ncs_hist_q <= 1'b0;
      sh_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < 5; i++) regs_q[i] <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sclk_sync_q <= SYNC_STAGES'({sclk_sync_q, sclk});
      copi_sync_q <= SYNC_STAGES'({copi_sync_q, copi});
      ncs_sync_q <= SYNC_STAGES'({ncs_sync_q, ncs});
      sclk_hist_q <= sclk_s;
      ncs_hist_q <= ncs_s;
      sh_q <= sh_d;
      cnt_q <= cnt_d;
      regs_q <= regs_d;
      valid_q <= valid_d;
      error_q <= error_d;
    end
  end
  assign en_reg_out_7_0 = regs_q[0];
  assign en_reg_out_15_8 = regs_q[1];
  assign en_reg_pwm_7_0 = regs_q[2];
  assign en_reg_pwm_15_8 = regs_q[3];
  assign pwm_duty_cycle = regs_q[4];
  assign txn_valid = valid_q;
  assign txn_error = error_q;
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: table-driven SPI frames with a pulse scoreboard and reset/back-to-back sequences
module tb_spi_peripheral;
  logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic [7:0] r0, r1, r2, r3, r4;
  logic txn_valid, txn_error;
  logic [39:0] regs;
  int checks = 0, errors = 0, npulse = 0;
  typedef struct packed {logic v; logic e; logic [39:0] regs;} exp_t;
  typedef struct {logic [31:0] bits; int n; logic v; logic e; logic [39:0] regs;} vec_t;
  exp_t sb[$];
  vec_t vt[15];
  always #5 clk = ~clk;
  spi_peripheral dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
    .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4),
    .txn_valid(txn_valid), .txn_error(txn_error)
  );
  assign regs = {r4, r3, r2, r1, r0};
  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic shift(input logic [31:0] b, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      copi = b[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask
  task automatic send(input logic [31:0] b, input int n);
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    shift(b, n);
    repeat (4) @(negedge clk);
    ncs = 1'b1;
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (!rst && (txn_valid || txn_error)) begin
      npulse++;
      if (sb.size() == 0) check("unexpected_pulse", 40'({txn_valid, txn_error}), 40'd0);
      else begin
        x = sb.pop_front();
        check("pulse_kind", 40'({txn_valid, txn_error}), 40'({x.v, x.e}));
        check("pulse_regs", regs, x.regs);
      end
    end
  end
  initial begin
    int first, cnt, p0;
    logic [39:0] m;
    logic [7:0] d;
    vt[0]  = '{32'h80F0, 16, 1, 0, 40'h00000000F0};
    vt[1]  = '{32'h8480, 16, 1, 0, 40'h80000000F0};
    vt[2]  = '{32'h82FF, 16, 1, 0, 40'h8000FF00F0};
    vt[3]  = '{32'h00AA, 16, 0, 0, 40'h8000FF00F0};
    vt[4]  = '{32'hB0AA, 16, 0, 1, 40'h8000FF00F0};
    vt[5]  = '{32'h40D5, 15, 0, 1, 40'h8000FF00F0};
    vt[6]  = '{32'h10357, 17, 0, 1, 40'h8000FF00F0};
    vt[7]  = '{32'h0, 0, 0, 1, 40'h8000FF00F0};
    vt[8]  = '{32'h835A, 16, 1, 0, 40'h805AFF00F0};
    vt[9]  = '{32'h835A, 16, 1, 0, 40'h805AFF00F0};
    vt[10] = '{32'h8511, 16, 0, 1, 40'h805AFF00F0};
    vt[11] = '{32'hFF00, 16, 0, 1, 40'h805AFF00F0};
    vt[12] = '{32'h0433, 16, 0, 0, 40'h805AFF00F0};
    vt[13] = '{32'h8177, 16, 1, 0, 40'h805AFF77F0};
    vt[14] = '{32'h8455, 16, 1, 0, 40'h555AFF77F0};
    repeat (4) @(negedge clk);
    check("reset_regs", regs, 40'd0);
    check("reset_pulses", 40'({txn_valid, txn_error}), 40'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      if (vt[i].v || vt[i].e) sb.push_back(exp_t'({vt[i].v, vt[i].e, vt[i].regs}));
      send(vt[i].bits, vt[i].n);
      first = 0;
      cnt = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (txn_valid || txn_error) begin
          cnt++;
          if (first == 0) first = k;
        end
      end
      check($sformatf("latency_%0d", i), 40'(first), (vt[i].v || vt[i].e) ? 40'd4 : 40'd0);
      check($sformatf("pulse_len_%0d", i), 40'(cnt), (vt[i].v || vt[i].e) ? 40'd1 : 40'd0);
      check($sformatf("regs_%0d", i), regs, vt[i].regs);
      check($sformatf("sb_empty_%0d", i), 40'(sb.size()), 40'd0);
    end
    ncs = 1'b0;
    repeat (4) @(negedge clk);
    shift(32'h80, 8);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midframe_reset_regs", regs, 40'd0);
    rst = 1'b0;
    p0 = npulse;
    shift(32'hFF, 8);
    repeat (4) @(negedge clk);
    ncs = 1'b1;
    repeat (12) @(negedge clk);
    check("midframe_no_pulse", 40'(npulse - p0), 40'd0);
    check("midframe_regs", regs, 40'd0);
    sb.push_back(exp_t'({1'b1, 1'b0, 40'h00000000FF}));
    send(32'h80FF, 16);
    repeat (10) @(negedge clk);
    check("after_reset_accept", regs, 40'h00000000FF);
    check("after_reset_sb", 40'(sb.size()), 40'd0);
    m = regs;
    p0 = npulse;
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h11 * (i + 1));
      m[i*8 +: 8] = d;
      sb.push_back(exp_t'({1'b1, 1'b0, m}));
      send(32'({1'b1, 7'(i), d}), 16);
      repeat (4) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("b2b_pulses", 40'(npulse - p0), 40'd5);
    check("b2b_regs", regs, 40'h5544332211);
    check("final_sb_empty", 40'(sb.size()), 40'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
